// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_sb register bank and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int X0         = 0;

    // busy_cnt must hold 0..NREGS-1, plus one bit of headroom for the popcount sum
    function automatic int cnt_w(input int nregs);
        return $clog2(nregs) + 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection: flush > alloc > writeback clear, plus a registered popcount.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alloc_en,
    input  logic [ADDR_W-1:0]           alloc_addr,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic                        flush,
    output logic [NREGS-1:0]            busy,
    output logic [cnt_w(NREGS)-1:0]     busy_cnt
);

    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(X0);

    logic [NREGS-1:0]        busy_nxt;
    logic [cnt_w(NREGS)-1:0] cnt_nxt;

    // Alloc is applied after the writeback clear so a same-cycle producer keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we && waddr != ZA)
                busy_nxt[waddr] = 1'b0;
            if (alloc_en && alloc_addr != ZA)
                busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{(cnt_w(NREGS)-1){1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register bank with x0 hard-wired to zero, busy scoreboard and debug read port.
// Optional write-through forwarding on read ports 1/2 when REGFILE_BYPASS_EN is defined.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NREGS  = DEF_NREGS,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(X0);

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  busy;
    logic              wr_hit;

    assign wr_hit = we && (waddr != ZA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (wr_hit) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .we         (we),
        .waddr      (waddr),
        .flush      (flush),
        .busy       (busy),
        .busy_cnt   (busy_cnt)
    );

    always_comb begin
        rdata1   = (raddr1 == ZA) ? '0 : mem[raddr1];
        rdata2   = (raddr2 == ZA) ? '0 : mem[raddr2];
        rbusy1   = busy[raddr1];
        rbusy2   = busy[raddr2];
        dbg_data = (dbg_addr == ZA) ? '0 : mem[dbg_addr];
`ifdef REGFILE_BYPASS_EN
        // The value being written back is forwarded and is no longer a pending hazard.
        if (wr_hit && raddr1 == waddr) begin
            rdata1 = wdata;
            rbusy1 = 1'b0;
        end
        if (wr_hit && raddr2 == waddr) begin
            rdata2 = wdata;
            rbusy2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 32x32 configuration).
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] raddr1, raddr2, waddr, alloc_addr, dbg_addr;
    logic [DATA_W-1:0] rdata1, rdata2, wdata, dbg_data;
    logic              rbusy1, rbusy2, we, alloc_en, flush;
    logic [ADDR_W:0]   busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; alloc_en = 0; flush = 0;
        waddr = '0; wdata = '0; alloc_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1;
        tick();
        we = 1; waddr = 5; wdata = 32'hAA; alloc_en = 1; alloc_addr = 3;
        tick();
        // write in flight to x6 is discarded by a mid-cycle reset
        we = 1; waddr = 6; wdata = 32'h66; alloc_en = 1; alloc_addr = 4;
        raddr1 = 5; raddr2 = 3; dbg_addr = 5;
        #2 rst_n = 0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg: got %h expected %h", dbg_data, 32'h0); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt); end
        checks++; if (rbusy2 !== 1'b0 || rbusy1 !== 1'b0) begin errors++; $display("FAIL reset_rbusy: got %b%b expected 00", rbusy1, rbusy2); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2: got %h expected %h", rdata2, 32'h0); end
        idle();
        tick();
        #2 rst_n = 1;
        for (int i = 1; i < NREGS; i++) begin
            raddr1 = ADDR_W'(i);
            #1;
            checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_clear x%0d: got %h expected 0", i, rdata1); end
        end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_post_cnt: got %0d expected 0", busy_cnt); end
    endtask

    task automatic test_write_read();
        idle();
        tick();
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        tick();
        waddr = 0; wdata = 32'h1234;
        tick();
        idle();
        raddr1 = 5; raddr2 = 0; dbg_addr = 5;
        #1;
        checks++; if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_x5: got %h expected %h", rdata1, 32'hDEADBEEF); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL wr_rd_x0: got %h expected %h", rdata2, 32'h0); end
        checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_dbg: got %h expected %h", dbg_data, 32'hDEADBEEF); end
        dbg_addr = 0;
        #1;
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL wr_rd_dbg_x0: got %h expected %h", dbg_data, 32'h0); end
    endtask

    task automatic test_scoreboard();
        idle();
        alloc_en = 1; alloc_addr = 7;
        tick();
        alloc_addr = 9;
        tick();
        idle();
        raddr1 = 7; raddr2 = 9;
        #1;
        checks++; if (busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_cnt2: got %0d expected 2", busy_cnt); end
        checks++; if (rbusy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_x7: got %b expected 1", rbusy1); end
        checks++; if (rbusy2 !== 1'b1) begin errors++; $display("FAIL sb_busy_x9: got %b expected 1", rbusy2); end
        we = 1; waddr = 7; wdata = 32'h11;
        tick();
        idle();
        #1;
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_after_wb: got %0d expected 1", busy_cnt); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL sb_clear_x7: got %b expected 0", rbusy1); end
        checks++; if (rdata1 !== 32'h11) begin errors++; $display("FAIL sb_data_x7: got %h expected %h", rdata1, 32'h11); end
        alloc_en = 1; alloc_addr = 0;
        tick();
        idle();
        raddr1 = 0;
        #1;
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_alloc_x0_cnt: got %0d expected 1", busy_cnt); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL sb_alloc_x0_busy: got %b expected 0", rbusy1); end
        // write to a register that is not busy leaves it idle
        we = 1; waddr = 12; wdata = 32'h12;
        tick();
        idle();
        raddr1 = 12;
        #1;
        checks++; if (rbusy1 !== 1'b0 || busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_idle_write: got busy %b cnt %0d expected 0 1", rbusy1, busy_cnt); end
    endtask

    task automatic test_same_cycle();
        idle();
        alloc_en = 1; alloc_addr = 3;
        tick();
        // re-allocate x3 and write it in the same cycle
        alloc_en = 1; alloc_addr = 3; we = 1; waddr = 3; wdata = 32'h33;
        tick();
        idle();
        raddr1 = 3;
        #1;
        checks++; if (rbusy1 !== 1'b1) begin errors++; $display("FAIL same_busy_x3: got %b expected 1", rbusy1); end
        checks++; if (rdata1 !== 32'h33) begin errors++; $display("FAIL same_data_x3: got %h expected %h", rdata1, 32'h33); end
        checks++; if (busy_cnt !== 6'd2) begin errors++; $display("FAIL same_cnt: got %0d expected 2", busy_cnt); end
    endtask

    task automatic test_flush();
        idle();
        alloc_en = 1; alloc_addr = 2; tick();
        alloc_addr = 4; tick();
        alloc_addr = 6; tick();
        idle();
        #1;
        checks++; if (busy_cnt !== 6'd5) begin errors++; $display("FAIL flush_pre_cnt: got %0d expected 5", busy_cnt); end
        flush = 1; alloc_en = 1; alloc_addr = 8; we = 1; waddr = 2; wdata = 32'h55;
        tick();
        idle();
        raddr1 = 8; raddr2 = 2;
        #1;
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", busy_cnt); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL flush_busy_x8: got %b expected 0", rbusy1); end
        checks++; if (rdata2 !== 32'h55) begin errors++; $display("FAIL flush_data_x2: got %h expected %h", rdata2, 32'h55); end
        checks++; if (rbusy2 !== 1'b0) begin errors++; $display("FAIL flush_busy_x2: got %b expected 0", rbusy2); end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; waddr = 10; wdata = 32'h1;
        tick();
        idle();
        alloc_en = 1; alloc_addr = 10;
        tick();
        idle();
        we = 1; waddr = 10; wdata = 32'hCAFE; raddr1 = 10; dbg_addr = 10;
        #1;
`ifdef REGFILE_BYPASS_EN
        checks++; if (rdata1 !== 32'hCAFE) begin errors++; $display("FAIL byp_pre_data: got %h expected %h", rdata1, 32'hCAFE); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL byp_pre_busy: got %b expected 0", rbusy1); end
`else
        checks++; if (rdata1 !== 32'h1) begin errors++; $display("FAIL byp_pre_data: got %h expected %h", rdata1, 32'h1); end
        checks++; if (rbusy1 !== 1'b1) begin errors++; $display("FAIL byp_pre_busy: got %b expected 1", rbusy1); end
`endif
        checks++; if (dbg_data !== 32'h1) begin errors++; $display("FAIL byp_dbg: got %h expected %h", dbg_data, 32'h1); end
        tick();
        idle();
        #1;
        checks++; if (rdata1 !== 32'hCAFE) begin errors++; $display("FAIL byp_post_data: got %h expected %h", rdata1, 32'hCAFE); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL byp_post_busy: got %b expected 0", rbusy1); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL byp_post_cnt: got %0d expected 0", busy_cnt); end
    endtask

    initial begin
        rst_n = 0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        idle();
        #12;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_cycle();
        test_flush();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
